// File: rtl/alu_pkg.sv
// Op encodings and divider state type shared by the execute-stage ALU and divider.
// Pure declarations; no logic, latency or flow control of its own.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_MUL = 4'b1111;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_REM = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract step producing one quotient bit; combinational.
// Zero latency; no flow control, the caller iterates it once per cycle.
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] div_x;
    logic             fits;

    // The dividend MSB shifts out of the quotient into the partial remainder.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign div_x  = {1'b0, div_i};
    assign fits   = (rem_sh >= div_x);

    assign rem_o = fits ? (WIDTH+1)'(rem_sh - div_x) : rem_sh[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle signed divide/remainder, one quotient bit per cycle; WIDTH+1 edges after accept (special cases 1).
// Accepts only when idle; holds result and flags under out_ready backpressure until the output handshake.
module alu_seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             illegal_op
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   div_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             op_rem_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             dbz_q;
    logic             ovf_q;
    logic             ill_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             op_is_rem;

    // A WIDTH-bit unsigned magnitude is exact even for the most negative value.
    assign a_mag = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign b_mag = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    assign op_is_rem = (ALUControl == ALU_REM);

    assign q_fix = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
    assign r_fix = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            op_rem_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_rem_q <= op_is_rem;
                        if (!is_div_op(ALUControl)) begin
                            res_q   <= '0;
                            ill_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (B == '0) begin
                            res_q   <= op_is_rem ? A : '1;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if ((A == MIN_VAL) && (&B)) begin
                            res_q   <= op_is_rem ? '0 : MIN_VAL;
                            ovf_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            div_q     <= {1'b0, b_mag};
                            neg_quo_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_rem_q <= A[WIDTH-1];
                            cnt_q     <= '0;
                            state_q   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    res_q       <= op_rem_q ? r_fix : q_fix;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    // Special cases arrive here with the result loaded but not yet presented.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        ill_q       <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign Result      = res_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed bench for the sequential signed divider with hand-computed expected values.
module tb_alu_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] ALUControl;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Result;
    logic       div_by_zero;
    logic       overflow;
    logic       illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_REM = 4'b0110;

    alu_seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .ALUControl  (ALUControl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one op and waits for out_valid; latency counts edges including the accept edge.
    task automatic issue(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input int exp_lat);
        int n;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = 4'h0; ALUControl = 4'h0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic result(input string tag, input logic [3:0] exp_res, input logic [2:0] exp_flags);
        check({tag, "_result"}, {28'd0, Result}, {28'd0, exp_res});
        check({tag, "_flags"}, {29'd0, div_by_zero, overflow, illegal_op}, {29'd0, exp_flags});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_after_hs"}, {27'd0, out_valid, in_ready, div_by_zero, overflow, illegal_op},
              32'b01000);
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] op, input int exp_lat,
                          input logic [3:0] exp_res, input logic [2:0] exp_flags);
        issue(tag, a, b, op, exp_lat);
        result(tag, exp_res, exp_flags);
        release_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 4'h0; B = 4'h0; ALUControl = 4'h0;
        #12;
        check("reset_outputs", {26'd0, in_ready, out_valid, Result, div_by_zero, overflow, illegal_op},
              32'b1_0_0000_000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Flags packed as {div_by_zero, overflow, illegal_op}.
        run_op("div_7_2",   4'h7, 4'h2, OP_DIV, 6, 4'h3, 3'b000);
        run_op("rem_7_2",   4'h7, 4'h2, OP_REM, 6, 4'h1, 3'b000);
        run_op("div_m7_2",  4'h9, 4'h2, OP_DIV, 6, 4'hD, 3'b000);
        run_op("rem_m7_2",  4'h9, 4'h2, OP_REM, 6, 4'hF, 3'b000);
        run_op("div_7_m2",  4'h7, 4'hE, OP_DIV, 6, 4'hD, 3'b000);
        run_op("rem_7_m2",  4'h7, 4'hE, OP_REM, 6, 4'h1, 3'b000);
        run_op("div_m8_3",  4'h8, 4'h3, OP_DIV, 6, 4'hE, 3'b000);
        run_op("rem_m8_3",  4'h8, 4'h3, OP_REM, 6, 4'hE, 3'b000);
        run_op("div_m8_1",  4'h8, 4'h1, OP_DIV, 6, 4'h8, 3'b000);
        run_op("div_5_0",   4'h5, 4'h0, OP_DIV, 2, 4'hF, 3'b100);
        run_op("rem_5_0",   4'h5, 4'h0, OP_REM, 2, 4'h5, 3'b100);
        run_op("div_m8_m1", 4'h8, 4'hF, OP_DIV, 2, 4'h8, 3'b010);
        run_op("rem_m8_m1", 4'h8, 4'hF, OP_REM, 2, 4'h0, 3'b010);

        // Backpressure: result held, new requests ignored.
        issue("bp", 4'h7, 4'h2, OP_DIV, 6);
        A = 4'h1; B = 4'h1; ALUControl = OP_REM; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {25'd0, out_valid, in_ready, Result, div_by_zero, overflow, illegal_op},
                  32'b1_0_0011_000);
        end
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_capture", {30'd0, out_valid, in_ready}, 32'b01);

        // Asynchronous reset in the middle of an iteration.
        A = 4'h7; B = 4'h2; ALUControl = OP_DIV; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", {26'd0, in_ready, out_valid, Result, div_by_zero, overflow, illegal_op},
              32'b1_0_0000_000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_no_result", {31'd0, out_valid}, 32'd0);
        end

        run_op("div_6_3",   4'h6, 4'h3, OP_DIV, 6, 4'h2, 3'b000);
        run_op("illegal",   4'h7, 4'h2, 4'b0000, 2, 4'h0, 3'b001);
        run_op("ill_prio",  4'h8, 4'h0, 4'b1111, 2, 4'h0, 3'b001);
        run_op("dbz_prio",  4'h8, 4'h0, OP_DIV, 2, 4'hF, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle signed divide/remainder unit; the inverse counterpart of the combinational add/multiply ALU slice.
- Sits beside that ALU in the execute stage and takes the same 4-bit signed operand pair.
- Uses a valid/ready handshake on both input and output, so issue logic can stall on it.
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle, with RISC-V divide-by-zero and overflow semantics.

Parameters:
- WIDTH, 4: operand and result width in bits; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- A  in  WIDTH  signed dividend.
- B  in  WIDTH  signed divisor.
- ALUControl  in  4  ALU_DIV (4'b0100) returns the quotient; ALU_REM (4'b0110) returns the remainder.
- out_valid  out  1  Result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  WIDTH  signed quotient or remainder, per the captured op.
- div_by_zero  out  1  B was 0.
- overflow  out  1  A was the most negative value and B was -1.
- illegal_op  out  1  captured op was neither DIV nor REM.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; internal registers clear.
  - out_valid, Result, div_by_zero, overflow and illegal_op are 0; in_ready is 1 after reset.
  - An operation in flight is discarded and no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&in_ready (edge E0), capture A, B and op.
  - Special cases at E0 go straight to DONE, so results are valid after E0+1:
    - B==0: Q=all ones (-1), R=A, div_by_zero=1.
    - A==min and B==-1: Q=min, R=0, overflow=1.
    - op illegal: Result=0, illegal_op=1.
    - Priority is illegal_op > div_by_zero > overflow.
  - Otherwise at E0:
    - Store |A| and |B|, each zero-extended to WIDTH+1 bits so |min| is representable.
    - Store sign_q = A[msb]^B[msb] and sign_r = A[msb].
    - Clear the iteration counter and go to CALC.
- CALC: exactly WIDTH edges (E1..E_WIDTH). Each edge does one restoring step:
  - Shift the remainder/quotient pair left by one.
  - Trial-subtract |B| from the remainder.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; else restore the remainder and set the LSB to 0.
  - The counter increments each step; it is ceil(log2(WIDTH+1)) bits wide.
  - After step WIDTH, go to FIX.
- FIX, one edge (E_WIDTH+1):
  - Negate Q if sign_q; negate R if sign_r.
  - Quotient truncates toward zero; remainder sign follows the dividend.
  - Load Result per op, set out_valid=1, go to DONE.
- Normal latency: out_valid is first high after edge E0+WIDTH+1, i.e. 6 edges for WIDTH=4.
- DONE:
  - Result and flags are held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On an edge with out_valid&out_ready, clear out_valid and all flags and return to IDLE.
  - in_ready rises the cycle after; there is no same-cycle accept.
- in_valid while busy is ignored and not captured; the upstream stage must hold its request.
- A, B and ALUControl changing after capture have no effect on the operation in flight.
- Widths: Result is truncated to WIDTH bits, which is exact for all non-overflow cases.

Decomposition:
- Shared package alu_pkg holds:
  - The op encodings ALU_ADD=4'b0000, ALU_MUL=4'b1111, ALU_DIV=4'b0100, ALU_REM=4'b0110, so the ALU and divider decode identically.
  - The divider state enum (IDLE, CALC, FIX, DONE).
- One sub-module: div_restore_step, combinational.
  - Inputs: the remainder/quotient pair and the divisor.
  - Outputs: the next pair.
  - The top module instantiates it once and iterates it in time.

Test Plan:
- Basic divide: A=7, B=2, DIV → Result=3 after exactly 6 edges from accept, flags 0. Repeat with REM → Result=1.
- Signed truncation: A=-7, B=2 → DIV=-3 and REM=-1. A=7, B=-2 → DIV=-3 and REM=1. A=-8, B=3 → DIV=-2 and REM=-2.
- Divide by zero: A=5, B=0 → DIV=-1 (4'hF) and REM=5, div_by_zero=1, valid 1 edge after accept.
- Overflow: A=-8, B=-1 → DIV=-8 and REM=0, overflow=1, valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 10 cycles → Result and flags stable; in_ready=0 throughout; a new in_valid is not captured. Then release → in_ready=1 one cycle after the completing handshake.
- Reset and illegal op:
  - Drop rst_n during CALC (after E2) → all outputs 0 immediately (asynchronous), no result after release.
  - Next op 6/3 DIV → Result=2.
  - ALUControl=4'b0000 → Result=0, illegal_op=1.
